icache_direct_mapped: RTL and testbench

//  Direct-mapped, read-only instruction cache; one 32-bit word per frame.

---
 rtl/icache_direct_mapped.sv | 127 ++++++++++++
 tb/tb_icache_direct_mapped.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache, one 32-bit word per frame, single-word refill.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_direct_mapped #(
   parameter int SETS  = 16,
   parameter int CPUID = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FETCH = 1'b1;

   // Slot selection in the shared ccif arrays is done by the wrapper.
   localparam int unused_cpuid = CPUID;

   logic [0:0]      state_q, state_d;
   logic [31:2]     faddr_q, faddr_d;
   logic [SETS-1:0] valid_q, valid_d;
   logic [TW-1:0]   tag_mem  [SETS];
   logic [31:0]     data_mem [SETS];

   logic [IW-1:0] idx, fidx;
   logic [TW-1:0] tag, ftag;
   logic          hit, fill;
   logic [1:0]    unused_offset;

   assign idx           = imemaddr[IW+1:2];
   assign tag           = imemaddr[31:IW+2];
   assign fidx          = faddr_q[IW+1:2];
   assign ftag          = faddr_q[31:IW+2];
   assign unused_offset = imemaddr[1:0];

   assign hit      = imemREN && valid_q[idx] && (tag_mem[idx] == tag);
   assign ihit     = hit && (state_q == IDLE);
   assign imemload = ihit ? data_mem[idx] : 32'h0;
   assign fill     = (state_q == FETCH) && !iwait;

   // The refill address is latched so a moving fetch address cannot corrupt the fill.
   assign iREN  = (state_q == FETCH);
   assign iaddr = iREN ? {faddr_q, 2'b00} : 32'h0;

   always_comb begin
      state_d = state_q;
      faddr_d = faddr_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (imemREN && !hit) begin
               state_d = FETCH;
               faddr_d = imemaddr[31:2];
            end
         end
         default: begin
            if (!iwait) begin
               valid_d[fidx] = 1'b1;
               state_d       = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         faddr_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         faddr_q <= faddr_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_mem[fidx]  <= ftag;
         data_mem[fidx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   logic        was_fetch_q;
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   // The hit that completes a refill is not counted as a hit.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (ihit && !was_fetch_q && (hit_count_q != 32'hFFFF_FFFF))
         hit_count_d = hit_count_q + 32'd1;
      if ((state_q == IDLE) && (state_d == FETCH) && (miss_count_q != 32'hFFFF_FFFF))
         miss_count_d = miss_count_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         was_fetch_q  <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         was_fetch_q  <= (state_q == FETCH);
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: fixed-latency ram model, frame-level reference model of the cache.
module tb_icache_direct_mapped;
   localparam int LAT  = 10;
   localparam int SETS = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   icache_direct_mapped #(.SETS(SETS), .CPUID(0)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   // ram: answers LAT cycles after a request is first seen, word[k] = A000_0000 + k
   int mem_cnt = 0;
   assign iwait = !(iREN && (mem_cnt == LAT));
   assign iload = iwait ? 32'hDEAD_BEEF : (32'hA000_0000 + (iaddr >> 2));
   always @(posedge CLK) begin
      if (!iREN || mem_cnt == LAT) mem_cnt <= 0;
      else                         mem_cnt <= mem_cnt + 1;
   end

   // reference model: which word address each frame holds
   bit          mv    [SETS];
   int unsigned mline [SETS];
   int unsigned exp_hits, exp_misses;

   function automatic bit model_hit(input logic [31:0] a);
      int unsigned w = a >> 2;
      return mv[w % SETS] && (mline[w % SETS] == w);
   endfunction

   function automatic void model_fill(input logic [31:0] a);
      int unsigned w = a >> 2;
      mv[w % SETS]    = 1'b1;
      mline[w % SETS] = w;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endfunction

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return 32'hA000_0000 + (a >> 2);
   endfunction

   // Issue one fetch and hold it until ihit; reports hit latency, data and bus behaviour.
   task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] data, output bit bus_ok);
      lat = -1; data = 32'h0; bus_ok = 1'b1;
      @(posedge CLK); #1;
      imemaddr = a; imemREN = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (ihit === 1'b1) begin
            lat = n; data = imemload;
            if (iREN !== 1'b0) bus_ok = 1'b0;
            break;
         end
         if (n == 0) begin
            if (iREN !== 1'b0) bus_ok = 1'b0;
         end else if (iREN !== 1'b1 || iaddr !== {a[31:2], 2'b00}) bus_ok = 1'b0;
      end
      @(posedge CLK); #1;
      imemREN = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK); RST = 1'b0;
      model_clear();
      @(negedge CLK);
      total_cnt++; if (ihit !== 1'b0)        $display("FAIL reset_ihit got %b want 0", ihit); else pass_cnt++;
      total_cnt++; if (iREN !== 1'b0)        $display("FAIL reset_iREN got %b want 0", iREN); else pass_cnt++;
      total_cnt++; if (imemload !== 32'h0)   $display("FAIL reset_imemload got %h want 0", imemload); else pass_cnt++;
      total_cnt++; if (iaddr !== 32'h0)      $display("FAIL reset_iaddr got %h want 0", iaddr); else pass_cnt++;
`ifdef ICACHE_STATS_EN
      total_cnt++; if (hit_count !== 32'h0)  $display("FAIL reset_hit_count got %0d want 0", hit_count); else pass_cnt++;
      total_cnt++; if (miss_count !== 32'h0) $display("FAIL reset_miss_count got %0d want 0", miss_count); else pass_cnt++;
`endif
   endtask

   // cold misses, a hit, then a conflict eviction
   task automatic test_directed();
      logic [31:0] addrs [6] = '{32'h00, 32'h04, 32'h08, 32'h08, 32'h40, 32'h00};
      bit          hits  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat; logic [31:0] data; bit ok;
      for (int i = 0; i < 6; i++) begin
         fetch(addrs[i], lat, data, ok);
         total_cnt++;
         if (lat != (hits[i] ? 0 : LAT + 2))
            $display("FAIL dir_latency[%0d] addr %h got %0d want %0d", i, addrs[i], lat, hits[i] ? 0 : LAT + 2);
         else pass_cnt++;
         total_cnt++;
         if (data !== ram_word(addrs[i])) $display("FAIL dir_data[%0d] got %h want %h", i, data, ram_word(addrs[i]));
         else pass_cnt++;
         total_cnt++;
         if (!ok) $display("FAIL dir_bus[%0d] addr %h iREN/iaddr wrong during fetch", i, addrs[i]);
         else pass_cnt++;
         if (hits[i]) exp_hits++;
         else begin exp_misses++; model_fill(addrs[i]); end
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] data; bit ok, eh;
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         a  = 32'(($urandom_range(3) * SETS + $urandom_range(SETS - 1)) * 4);
         eh = model_hit(a);
         fetch(a, lat, data, ok);
         total_cnt++;
         if (lat != (eh ? 0 : LAT + 2)) $display("FAIL rand_latency addr %h got %0d want %0d", a, lat, eh ? 0 : LAT + 2);
         else pass_cnt++;
         total_cnt++;
         if (data !== ram_word(a)) $display("FAIL rand_data addr %h got %h want %h", a, data, ram_word(a));
         else pass_cnt++;
         total_cnt++;
         if (!ok) $display("FAIL rand_bus addr %h iREN/iaddr wrong during fetch", a);
         else pass_cnt++;
         if (eh) exp_hits++;
         else begin exp_misses++; model_fill(a); end
      end
`ifdef ICACHE_STATS_EN
      total_cnt++; if (hit_count !== exp_hits)    $display("FAIL rand_hit_count got %0d want %0d", hit_count, exp_hits); else pass_cnt++;
      total_cnt++; if (miss_count !== exp_misses) $display("FAIL rand_miss_count got %0d want %0d", miss_count, exp_misses); else pass_cnt++;
`endif
   endtask

   // consecutive-cycle hits on different frames
   task automatic test_back_to_back();
      logic [31:0] addrs [4] = '{32'h20, 32'h24, 32'h28, 32'h2C};
      int lat; logic [31:0] data; bit ok;
      for (int i = 0; i < 4; i++) begin
         if (model_hit(addrs[i])) exp_hits++;
         else begin exp_misses++; model_fill(addrs[i]); end
         fetch(addrs[i], lat, data, ok);
      end
      @(posedge CLK); #1;
      imemREN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         imemaddr = addrs[i];
         @(negedge CLK);
         total_cnt++;
         if (ihit !== 1'b1 || imemload !== ram_word(addrs[i]))
            $display("FAIL b2b_hit[%0d] got ihit=%b data=%h want ihit=1 data=%h", i, ihit, imemload, ram_word(addrs[i]));
         else pass_cnt++;
         exp_hits++;
         @(posedge CLK); #1;
      end
      imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
      total_cnt++; if (hit_count !== exp_hits) $display("FAIL b2b_hit_count got %0d want %0d", hit_count, exp_hits); else pass_cnt++;
`endif
   endtask

   // address moves mid-refill: the latched word fills, then the new one is fetched
   task automatic test_addr_change();
      logic [31:0] a = 32'h1C4, b = 32'h188;
      int lat; logic [31:0] data; bit ok;
      @(posedge CLK); #1;
      imemaddr = a; imemREN = 1'b1;
      repeat (3) @(negedge CLK);
      #1 imemaddr = b;
      lat = -1;
      for (int n = 3; n < 200; n++) begin
         @(negedge CLK);
         if (n == 3) begin
            total_cnt++;
            if (iaddr !== a) $display("FAIL chg_iaddr got %h want %h", iaddr, a); else pass_cnt++;
         end
         if (ihit === 1'b1) begin lat = n; data = imemload; break; end
      end
      total_cnt++;
      if (lat != 2 * (LAT + 2)) $display("FAIL chg_latency got %0d want %0d", lat, 2 * (LAT + 2)); else pass_cnt++;
      total_cnt++;
      if (data !== ram_word(b)) $display("FAIL chg_data got %h want %h", data, ram_word(b)); else pass_cnt++;
      @(posedge CLK); #1;
      imemREN = 1'b0;
      model_fill(a); model_fill(b); exp_misses += 2;
      fetch(a, lat, data, ok);
      total_cnt++;
      if (lat != 0 || data !== ram_word(a)) $display("FAIL chg_old_fill got lat=%0d data=%h want lat=0 data=%h", lat, data, ram_word(a));
      else pass_cnt++;
      exp_hits++;
`ifdef ICACHE_STATS_EN
      total_cnt++; if (miss_count !== exp_misses) $display("FAIL chg_miss_count got %0d want %0d", miss_count, exp_misses); else pass_cnt++;
      total_cnt++; if (hit_count !== exp_hits)     $display("FAIL chg_hit_count got %0d want %0d", hit_count, exp_hits); else pass_cnt++;
`endif
   endtask

   task automatic test_rst_mid_fetch();
      int lat; logic [31:0] data; bit ok;
      @(posedge CLK); #1;
      imemaddr = 32'h1C0; imemREN = 1'b1;
      repeat (4) @(negedge CLK);
      total_cnt++; if (iREN !== 1'b1) $display("FAIL rst_pre_iREN got %b want 1", iREN); else pass_cnt++;
      #1 RST = 1'b1;
      #1;
      total_cnt++; if (iREN !== 1'b0) $display("FAIL rst_iREN_drop got %b want 0", iREN); else pass_cnt++;
      total_cnt++; if (iaddr !== 32'h0) $display("FAIL rst_iaddr got %h want 0", iaddr); else pass_cnt++;
      imemREN = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK); #1 RST = 1'b0;
      model_clear();
`ifdef ICACHE_STATS_EN
      total_cnt++; if (hit_count !== 32'h0)  $display("FAIL rst_hit_count got %0d want 0", hit_count); else pass_cnt++;
      total_cnt++; if (miss_count !== 32'h0) $display("FAIL rst_miss_count got %0d want 0", miss_count); else pass_cnt++;
`endif
      fetch(32'h04, lat, data, ok);
      total_cnt++;
      if (lat != LAT + 2) $display("FAIL rst_refetch_latency got %0d want %0d", lat, LAT + 2); else pass_cnt++;
      total_cnt++;
      if (data !== 32'hA000_0001) $display("FAIL rst_refetch_data got %h want a0000001", data); else pass_cnt++;
      fetch(32'h1C0, lat, data, ok);
      total_cnt++;
      if (lat != LAT + 2 || data !== ram_word(32'h1C0))
         $display("FAIL rst_aborted_frame got lat=%0d data=%h want lat=%0d data=%h", lat, data, LAT + 2, ram_word(32'h1C0));
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_addr_change();
      test_rst_mid_fetch();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
